// File: rtl/snake_score_keeper.sv
// -----------------------------------------------------------------------------
// snake_score_keeper
//
// Score and game-state keeper for the snake game. It counts rising edges of
// goodColl as apples and rising edges of badColl as hits. It keeps the
// current score, the session high score and the remaining lives. It runs an
// IDLE/PLAY/OVER/WIN game FSM, and a rising edge of start begins a new game.
//
// Parameters
//   SCORE_W    width of currScore/highScore
//   WIN_SCORE  score that ends the game as a win (1 .. 2^SCORE_W-1)
//   LIVES      hits allowed per game (1 .. 7)
//   AUTO_START 1: PLAY straight out of reset, 0: wait in IDLE for start
//
// Ports
//   clk            system clock, rising edge
//   nRst           asynchronous active-low reset
//   start          level, rising edge starts/restarts a game
//   goodColl       level, rising edge = one apple
//   badColl        level, rising edge = one hit
//   currScore      score of the current game (registered)
//   highScore      highest score since reset (registered)
//   livesLeft      remaining lives (registered)
//   gameState      00 IDLE, 01 PLAY, 10 OVER, 11 WIN (registered)
//   isGameComplete high in OVER or WIN (decoded from gameState)
//   isWin          high in WIN (decoded from gameState)
//   newHigh        one-cycle pulse on each highScore update (registered)
// -----------------------------------------------------------------------------
module snake_score_keeper #(
  parameter int SCORE_W    = 7,
  parameter int WIN_SCORE  = 99,
  parameter int LIVES      = 1,
  parameter int AUTO_START = 1
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               goodColl,
  input  logic               badColl,
  output logic [SCORE_W-1:0] currScore,
  output logic [SCORE_W-1:0] highScore,
  output logic [2:0]         livesLeft,
  output logic [1:0]         gameState,
  output logic               isGameComplete,
  output logic               isWin,
  output logic               newHigh
);

  if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win_score
    $error("snake_score_keeper: WIN_SCORE must be in 1..2^SCORE_W-1");
  end
  if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
    $error("snake_score_keeper: LIVES must be in 1..7");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_OVER = 2'b10,
    ST_WIN  = 2'b11
  } state_e;

  localparam state_e             RESET_STATE = (AUTO_START != 0) ? ST_PLAY : ST_IDLE;
  localparam logic [SCORE_W-1:0] WIN_VAL     = SCORE_W'(WIN_SCORE);
  localparam logic [2:0]         LIVES_VAL   = 3'(LIVES);

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [2:0]         lives_q, lives_d;
  logic               new_high_q, new_high_d;
  logic               start_q, good_q, bad_q;

  logic               start_ev, good_ev, bad_ev;
  logic [SCORE_W-1:0] score_inc;

  // Registered copies of the inputs. An event is a 0->1 step between
  // consecutive samples, so a held level counts only once.
  assign start_ev  = start    & ~start_q;
  assign good_ev   = goodColl & ~good_q;
  assign bad_ev    = badColl  & ~bad_q;
  // Cannot wrap: WIN is entered as soon as the score reaches WIN_VAL.
  assign score_inc = score_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets its hold value first so that no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    lives_d    = lives_q;
    new_high_d = 1'b0;

    case (state_q)
      ST_PLAY: begin
        // A hit takes priority over an apple in the same cycle.
        if (bad_ev) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = ST_OVER;
          end
        end else if (good_ev) begin
          score_d = score_inc;
          if (score_inc > high_q) begin
            high_d     = score_inc;
            new_high_d = 1'b1;
          end
          if (score_inc == WIN_VAL) begin
            state_d = ST_WIN;
          end
        end
      end
      default: begin
        // IDLE, OVER and WIN: collisions are ignored and start begins a game.
        if (start_ev) begin
          state_d = ST_PLAY;
          score_d = '0;
          lives_d = LIVES_VAL;
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so that every register samples
  // the pre-edge values, whatever order the simulator evaluates blocks in.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= RESET_STATE;
      score_q    <= '0;
      high_q     <= '0;
      lives_q    <= LIVES_VAL;
      new_high_q <= 1'b0;
      start_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      lives_q    <= lives_d;
      new_high_q <= new_high_d;
      start_q    <= start;
      good_q     <= goodColl;
      bad_q      <= badColl;
    end
  end

  assign currScore      = score_q;
  assign highScore      = high_q;
  assign livesLeft      = lives_q;
  assign gameState      = state_q;
  assign newHigh        = new_high_q;
  assign isGameComplete = (state_q == ST_OVER) || (state_q == ST_WIN);
  assign isWin          = (state_q == ST_WIN);

endmodule

// File: tb/tb_snake_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_snake_score_keeper
//
// Three keepers with different configurations share one stimulus stream:
//   a: SCORE_W=7, WIN_SCORE=99, LIVES=3, AUTO_START=1
//   b: SCORE_W=7, WIN_SCORE=99, LIVES=1, AUTO_START=1
//   c: SCORE_W=3, WIN_SCORE=5,  LIVES=2, AUTO_START=0
// A game-rule model per instance is compared on every falling edge. Literal
// expectations at key points pin the model to the intended game story.
// -----------------------------------------------------------------------------
module tb_snake_score_keeper;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_OVER = 2;
  localparam int M_WIN  = 3;

  typedef struct {
    int st;
    int score;
    int high;
    int lives;
    bit nh;
    bit ps;
    bit pg;
    bit pb;
  } mdl_t;

  logic clk;
  logic nRst;
  logic start, goodColl, badColl;

  logic [6:0] a_score, a_high, b_score, b_high;
  logic [2:0] c_score, c_high;
  logic [2:0] a_lives, b_lives, c_lives;
  logic [1:0] a_state, b_state, c_state;
  logic       a_cmp, a_win, a_nh;
  logic       b_cmp, b_win, b_nh;
  logic       c_cmp, c_win, c_nh;

  int n_cmp  = 0;
  int n_fail = 0;
  int nh_a   = 0;
  int nh_b   = 0;

  mdl_t ma, mb, mc;

  snake_score_keeper #(.SCORE_W(7), .WIN_SCORE(99), .LIVES(3), .AUTO_START(1)) u_a (
    .clk(clk), .nRst(nRst), .start(start), .goodColl(goodColl), .badColl(badColl),
    .currScore(a_score), .highScore(a_high), .livesLeft(a_lives), .gameState(a_state),
    .isGameComplete(a_cmp), .isWin(a_win), .newHigh(a_nh)
  );

  snake_score_keeper #(.SCORE_W(7), .WIN_SCORE(99), .LIVES(1), .AUTO_START(1)) u_b (
    .clk(clk), .nRst(nRst), .start(start), .goodColl(goodColl), .badColl(badColl),
    .currScore(b_score), .highScore(b_high), .livesLeft(b_lives), .gameState(b_state),
    .isGameComplete(b_cmp), .isWin(b_win), .newHigh(b_nh)
  );

  snake_score_keeper #(.SCORE_W(3), .WIN_SCORE(5), .LIVES(2), .AUTO_START(0)) u_c (
    .clk(clk), .nRst(nRst), .start(start), .goodColl(goodColl), .badColl(badColl),
    .currScore(c_score), .highScore(c_high), .livesLeft(c_lives), .gameState(c_state),
    .isGameComplete(c_cmp), .isWin(c_win), .newHigh(c_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Game-rule model
  // ---------------------------------------------------------------------------
  function automatic mdl_t mdl_reset(int lives, int auto_start);
    mdl_t m;
    m.st    = (auto_start != 0) ? M_PLAY : M_IDLE;
    m.score = 0;
    m.high  = 0;
    m.lives = lives;
    m.nh    = 1'b0;
    m.ps    = 1'b0;
    m.pg    = 1'b0;
    m.pb    = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int win, int lives, bit s, bit g, bit b);
    mdl_t n;
    bit   s_new, g_new, b_new;
    n     = m;
    s_new = s && !m.ps;
    g_new = g && !m.pg;
    b_new = b && !m.pb;
    n.nh  = 1'b0;
    n.ps  = s;
    n.pg  = g;
    n.pb  = b;
    if (m.st == M_PLAY) begin
      if (b_new) begin
        n.lives = m.lives - 1;
        if (n.lives == 0) n.st = M_OVER;
      end else if (g_new) begin
        n.score = m.score + 1;
        if (n.score > m.high) begin
          n.high = n.score;
          n.nh   = 1'b1;
        end
        if (n.score == win) n.st = M_WIN;
      end
    end else if (s_new) begin
      n.st    = M_PLAY;
      n.score = 0;
      n.lives = lives;
    end
    return n;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ma <= mdl_reset(3, 1);
      mb <= mdl_reset(1, 1);
      mc <= mdl_reset(2, 0);
    end else begin
      ma <= mdl_step(ma, 99, 3, start, goodColl, badColl);
      mb <= mdl_step(mb, 99, 1, start, goodColl, badColl);
      mc <= mdl_step(mc, 5, 2, start, goodColl, badColl);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(string tag, mdl_t m, logic [31:0] sc, logic [31:0] hi,
                          logic [31:0] lv, logic [31:0] st, logic [31:0] gc,
                          logic [31:0] w, logic [31:0] nh);
    check({tag, ".currScore"}, sc, m.score);
    check({tag, ".highScore"}, hi, m.high);
    check({tag, ".livesLeft"}, lv, m.lives);
    check({tag, ".gameState"}, st, m.st);
    check({tag, ".isGameComplete"}, gc, (m.st == M_OVER || m.st == M_WIN) ? 1 : 0);
    check({tag, ".isWin"}, w, (m.st == M_WIN) ? 1 : 0);
    check({tag, ".newHigh"}, nh, m.nh ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (nRst === 1'b1) begin
      cmp_inst("a", ma, 32'(a_score), 32'(a_high), 32'(a_lives), 32'(a_state),
               32'(a_cmp), 32'(a_win), 32'(a_nh));
      cmp_inst("b", mb, 32'(b_score), 32'(b_high), 32'(b_lives), 32'(b_state),
               32'(b_cmp), 32'(b_win), 32'(b_nh));
      cmp_inst("c", mc, 32'(c_score), 32'(c_high), 32'(c_lives), 32'(c_state),
               32'(c_cmp), 32'(c_win), 32'(c_nh));
      if (a_nh === 1'b1) nh_a++;
      if (b_nh === 1'b1) nh_b++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Drive the given levels for hi_cycles sampled edges, then hold everything
  // low for one sampled edge so the next call is a fresh rising edge.
  task automatic drive(bit s, bit g, bit b, int hi_cycles);
    @(negedge clk);
    start    = s;
    goodColl = g;
    badColl  = b;
    repeat (hi_cycles) @(negedge clk);
    start    = 1'b0;
    goodColl = 1'b0;
    badColl  = 1'b0;
    @(negedge clk);
  endtask

  int nh_before;

  initial begin
    nRst     = 1'b0;
    start    = 1'b0;
    goodColl = 1'b0;
    badColl  = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst.a.gameState", 32'(a_state), 1);
    check("rst.c.gameState", 32'(c_state), 0);
    check("rst.a.livesLeft", 32'(a_lives), 3);
    check("rst.c.livesLeft", 32'(c_lives), 2);
    check("rst.a.currScore", 32'(a_score), 0);

    // Four single-cycle apples
    nh_before = nh_a;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1);
      check($sformatf("step%0d.a.currScore", i), 32'(a_score), 32'(i));
      check($sformatf("step%0d.a.highScore", i), 32'(a_high), 32'(i));
    end
    check("step.a.newHigh_count", 32'(nh_a - nh_before), 4);
    check("idle.c.currScore", 32'(c_score), 0);

    // Held goodColl counts once
    drive(1'b0, 1'b1, 1'b0, 10);
    check("held.a.currScore", 32'(a_score), 5);
    check("held.b.currScore", 32'(b_score), 5);

    // Asynchronous reset mid-game, checked before any clock edge
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("arst.a.currScore", 32'(a_score), 0);
    check("arst.a.highScore", 32'(a_high), 0);
    check("arst.a.livesLeft", 32'(a_lives), 3);
    check("arst.a.gameState", 32'(a_state), 1);
    check("arst.a.newHigh", 32'(a_nh), 0);
    check("arst.a.isGameComplete", 32'(a_cmp), 0);
    check("arst.a.isWin", 32'(a_win), 0);
    check("arst.b.currScore", 32'(b_score), 0);
    @(negedge clk);
    nRst = 1'b1;

    // Score 4 everywhere that plays; c still idles
    repeat (4) drive(1'b0, 1'b1, 1'b0, 1);
    check("s4.b.currScore", 32'(b_score), 4);
    check("s4.c.currScore", 32'(c_score), 0);

    // start: only c (IDLE) reacts
    drive(1'b1, 1'b0, 1'b0, 1);
    check("start1.c.gameState", 32'(c_state), 1);
    check("start1.a.currScore", 32'(a_score), 4);

    // One hit: a 3->2, b game over, c 2->1
    drive(1'b0, 1'b0, 1'b1, 1);
    check("hit1.a.livesLeft", 32'(a_lives), 2);
    check("hit1.b.gameState", 32'(b_state), 2);
    check("hit1.b.isGameComplete", 32'(b_cmp), 1);
    check("hit1.b.livesLeft", 32'(b_lives), 0);
    check("hit1.c.livesLeft", 32'(c_lives), 1);

    // Restart b, high score retained
    drive(1'b1, 1'b0, 1'b0, 1);
    check("restart.b.gameState", 32'(b_state), 1);
    check("restart.b.currScore", 32'(b_score), 0);
    check("restart.b.livesLeft", 32'(b_lives), 1);
    check("restart.b.highScore", 32'(b_high), 4);

    nh_before = nh_b;
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1);
    check("keep.b.highScore", 32'(b_high), 4);
    check("keep.b.newHigh_count", 32'(nh_b - nh_before), 0);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1);
    check("beat.b.highScore", 32'(b_high), 5);
    check("beat.b.newHigh_count", 32'(nh_b - nh_before), 1);
    check("win.c.currScore", 32'(c_score), 5);
    check("win.c.gameState", 32'(c_state), 3);
    check("win.c.isWin", 32'(c_win), 1);

    drive(1'b0, 1'b1, 1'b0, 1);
    check("postwin.c.currScore", 32'(c_score), 5);
    check("postwin.a.currScore", 32'(a_score), 10);

    // Two more hits end game a; c ignores hits in WIN
    repeat (2) drive(1'b0, 1'b0, 1'b1, 1);
    check("over.a.gameState", 32'(a_state), 2);
    check("over.a.livesLeft", 32'(a_lives), 0);
    check("winhit.c.livesLeft", 32'(c_lives), 1);
    drive(1'b0, 1'b1, 1'b0, 1);
    check("over.a.currScore", 32'(a_score), 10);

    // start together with an apple while over: only the start counts
    drive(1'b1, 1'b1, 1'b0, 1);
    check("startgood.a.currScore", 32'(a_score), 0);
    check("startgood.a.livesLeft", 32'(a_lives), 3);
    check("startgood.c.gameState", 32'(c_state), 1);

    // Simultaneous apple and hit at score 2: hit wins
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1);
    check("pre.c.currScore", 32'(c_score), 2);
    drive(1'b0, 1'b1, 1'b1, 1);
    check("both.c.currScore", 32'(c_score), 2);
    check("both.c.livesLeft", 32'(c_lives), 1);
    check("both.a.currScore", 32'(a_score), 2);
    check("both.b.gameState", 32'(b_state), 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
